io_fifo_bridge: RTL and testbench

//   Memory-mapped FIFO I/O port for one core's RD/WR/ADDR/DATA bus; replaces the bare OUTn/INn latch with buffered streams.

---
 rtl/io_fifo_bridge_if.sv | 25 ++
 rtl/io_fifo_bridge.sv | 145 ++++++++++++++
 tb/tb_io_fifo_bridge.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_fifo_bridge_if.sv
// Bus and stream signals of one core's FIFO I/O port.
// The bridge takes the slave side; the core/soc and external stream endpoints take the master side.
interface io_fifo_bridge_if #(parameter int DW = 12) ();
  logic          BUS_RD;
  logic          BUS_WR;
  logic [15:0]   BUS_ADDR;
  logic [15:0]   BUS_WDATA;
  logic [15:0]   BUS_RDATA;
  logic [DW-1:0] TX_DATA;
  logic          TX_VALID;
  logic          TX_READY;
  logic [DW-1:0] RX_DATA;
  logic          RX_VALID;
  logic          RX_READY;

  modport master (
    output BUS_RD, BUS_WR, BUS_ADDR, BUS_WDATA, TX_READY, RX_DATA, RX_VALID,
    input  BUS_RDATA, TX_DATA, TX_VALID, RX_READY
  );

  modport slave (
    input  BUS_RD, BUS_WR, BUS_ADDR, BUS_WDATA, TX_READY, RX_DATA, RX_VALID,
    output BUS_RDATA, TX_DATA, TX_VALID, RX_READY
  );
endinterface

// File: rtl/io_fifo_bridge.sv
// Memory-mapped FIFO I/O port: core writes feed a TX stream FIFO, core reads drain an RX stream FIFO.
// Data register at BASE, status/control register at BASE+1.
module io_fifo_bridge #(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          DW    = 12,
  parameter int          DEPTH = 8,
  parameter int          AW    = 3
) (
  input logic          CLK,
  input logic          RES,
  io_fifo_bridge_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic          tx_ovf, rx_udf, rdy_en;

  logic sel, dsel, ssel;
  logic tx_wr, rx_rd, st_wr;
  logic tx_flush, rx_flush, flag_clr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [15:0] status;
  logic unused_wdata;

  assign sel  = (bus.BUS_ADDR[15:1] == BASE[15:1]);
  assign dsel = sel & ~bus.BUS_ADDR[0];
  assign ssel = sel &  bus.BUS_ADDR[0];

  assign tx_wr    = bus.BUS_WR & dsel;
  assign rx_rd    = bus.BUS_RD & dsel;
  assign st_wr    = bus.BUS_WR & ssel;
  assign tx_flush = st_wr & bus.BUS_WDATA[0];
  assign rx_flush = st_wr & bus.BUS_WDATA[1];
  assign flag_clr = st_wr & bus.BUS_WDATA[2];

  // Upper write-data bits beyond the stream width are intentionally ignored.
  assign unused_wdata = ^bus.BUS_WDATA;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // Full/empty are pre-edge: a same-edge pop never makes room for a push.
  assign tx_push = tx_wr & ~tx_full;
  assign tx_pop  = bus.TX_VALID & bus.TX_READY;
  assign rx_push = bus.RX_VALID & bus.RX_READY;
  assign rx_pop  = rx_rd & ~rx_empty;

  assign bus.TX_VALID = ~tx_empty;
  assign bus.TX_DATA  = tx_empty ? '0 : tx_mem[tx_rp];
  assign bus.RX_READY = rdy_en & ~rx_full;

  assign status = {4'b0000, rx_udf, tx_ovf, tx_full, rx_empty, 4'(tx_cnt), 4'(rx_cnt)};

  always_comb begin
    bus.BUS_RDATA = '0;
    if (dsel && !rx_empty)
      bus.BUS_RDATA = 16'(rx_mem[rx_rp]);
    else if (ssel)
      bus.BUS_RDATA = status;
  end

  // Storage is not reset; only pointers and counts define what is valid.
  always_ff @(posedge CLK) begin
    if (tx_push)
      tx_mem[tx_wp] <= DW'(bus.BUS_WDATA);
    if (rx_push)
      rx_mem[rx_wp] <= bus.RX_DATA;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push)
        tx_wp <= tx_wp + 1'b1;
      if (tx_pop)
        tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push)
        rx_wp <= rx_wp + 1'b1;
      if (rx_pop)
        rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Sticky error flags; an explicit clear wins over a set on the same edge.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else if (flag_clr) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (tx_wr && tx_full)
        tx_ovf <= 1'b1;
      if (rx_rd && rx_empty)
        rx_udf <= 1'b1;
    end
  end

  // Holds RX_READY low for the first cycle after reset release.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)
      rdy_en <= 1'b0;
    else
      rdy_en <= 1'b1;
  end

endmodule

// File: tb/tb_io_fifo_bridge.sv
// Scoreboard bench for io_fifo_bridge: queue-based reference model, directed scenarios, then random traffic.
module tb_io_fifo_bridge;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] STAT  = 16'hFF01;
  localparam int          DEPTH = 8;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  io_fifo_bridge_if #(.DW(12)) bi ();
  io_fifo_bridge #(.BASE(BASE), .DW(12), .DEPTH(DEPTH), .AW(3)) dut (.CLK(clk), .RES(res), .bus(bi));

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as queues, plus flags.
  logic [11:0] m_tx[$];
  logic [11:0] m_rx[$];
  logic        m_ovf = 1'b0, m_udf = 1'b0, m_rdy = 1'b0;

  // Scoreboard queues and per-cycle expected handshake outputs.
  logic [11:0] sb_tx[$];
  logic [15:0] sb_rd[$];
  logic        exp_txv = 1'b0, exp_rxr = 1'b0;
  logic [11:0] exp_txd = '0;
  logic        mon_en = 1'b0;

  logic        g_txr = 1'b0, g_rxv = 1'b0, g_rand = 1'b0;
  logic [11:0] g_rxd = 12'd1;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {4'b0000, m_udf, m_ovf, (m_tx.size() == DEPTH), (m_rx.size() == 0),
            4'(m_tx.size()), 4'(m_rx.size())};
  endfunction

  // Drive one cycle's inputs, record expected outputs, advance the model across the coming edge.
  task automatic cyc(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wd);
    logic dsel, ssel, txfull, rxempty, txpop, rxpush;
    bi.BUS_RD    = rd;
    bi.BUS_WR    = wr;
    bi.BUS_ADDR  = addr;
    bi.BUS_WDATA = wd;
    bi.TX_READY  = g_txr;
    bi.RX_VALID  = g_rxv;
    bi.RX_DATA   = g_rxd;
    dsel    = (addr[15:1] == BASE[15:1]) && !addr[0];
    ssel    = (addr[15:1] == BASE[15:1]) &&  addr[0];
    exp_txv = (m_tx.size() != 0);
    exp_txd = exp_txv ? m_tx[0] : 12'h000;
    exp_rxr = m_rdy && (m_rx.size() < DEPTH);
    txfull  = (m_tx.size() == DEPTH);
    rxempty = (m_rx.size() == 0);
    if (rd && dsel) sb_rd.push_back(rxempty ? 16'h0000 : 16'(m_rx[0]));
    if (rd && ssel) sb_rd.push_back(m_status());
    txpop  = exp_txv && g_txr;
    rxpush = g_rxv && exp_rxr;
    if (txpop) sb_tx.push_back(m_tx[0]);
    if (wr && ssel && wd[0]) m_tx.delete();
    else begin
      if (txpop) void'(m_tx.pop_front());
      if (wr && dsel && !txfull) m_tx.push_back(wd[11:0]);
    end
    if (wr && ssel && wd[1]) m_rx.delete();
    else begin
      if (rd && dsel && !rxempty) void'(m_rx.pop_front());
      if (rxpush) m_rx.push_back(g_rxd);
    end
    if (wr && ssel && wd[2]) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && dsel && txfull) m_ovf = 1'b1;
      if (rd && dsel && rxempty) m_udf = 1'b1;
    end
    m_rdy = 1'b1;
    if (rxpush) g_rxd = g_rand ? 12'($urandom) : g_rxd + 12'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 16'h0000);
  endtask

  // Asynchronous reset pulse, asserted between clock edges.
  task automatic do_reset();
    #2;
    res = 1'b1;
    #1;
    check("rst_tx_valid", 16'(bi.TX_VALID), 16'h0000);
    check("rst_tx_data", 16'(bi.TX_DATA), 16'h0000);
    check("rst_rx_ready", 16'(bi.RX_READY), 16'h0000);
    bi.BUS_RD = 1'b0;
    bi.BUS_WR = 1'b0;
    bi.BUS_ADDR = STAT;
    #1;
    check("rst_status", bi.BUS_RDATA, 16'h0100);
    m_tx.delete(); m_rx.delete(); sb_tx.delete(); sb_rd.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_rdy = 1'b0;
    exp_txv = 1'b0; exp_rxr = 1'b0; exp_txd = '0;
    @(posedge clk);
    #3;
    res = 1'b0;
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    check("rx_ready_after_release", 16'(bi.RX_READY), 16'h0001);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard, half a cycle from the edge.
  always @(negedge clk) begin
    if (mon_en && !res) begin
      check("tx_valid", 16'(bi.TX_VALID), 16'(exp_txv));
      check("rx_ready", 16'(bi.RX_READY), 16'(exp_rxr));
      if (bi.TX_VALID) check("tx_head", 16'(bi.TX_DATA), 16'(exp_txd));
      else             check("tx_data_idle", 16'(bi.TX_DATA), 16'h0000);
      if (bi.TX_VALID && bi.TX_READY) begin
        if (sb_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_drain actual=%h required=none t=%0t", bi.TX_DATA, $time);
        end else check("tx_drain", 16'(bi.TX_DATA), 16'(sb_tx.pop_front()));
      end
      if (bi.BUS_ADDR[15:1] != BASE[15:1]) check("rdata_unsel", bi.BUS_RDATA, 16'h0000);
      else if (bi.BUS_RD) begin
        if (sb_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_read actual=%h required=none t=%0t", bi.BUS_RDATA, $time);
        end else check("bus_read", bi.BUS_RDATA, sb_rd.pop_front());
      end
    end
  end

  initial begin
    int txbias, rxbias, op;
    logic [15:0] wd, a;
    bi.BUS_RD = 1'b0; bi.BUS_WR = 1'b0; bi.BUS_ADDR = BASE; bi.BUS_WDATA = '0;
    bi.TX_READY = 1'b0; bi.RX_VALID = 1'b0; bi.RX_DATA = '0;
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // Two words, then drain back to back.
    cyc(1'b0, 1'b1, BASE, 16'h0ABC);
    cyc(1'b0, 1'b1, BASE, 16'h0123);
    cyc(1'b1, 1'b0, STAT, 16'h0000);
    g_txr = 1'b1; idle(3); g_txr = 1'b0;

    // Overflow: ninth word dropped, flag sticky until cleared.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, BASE, 16'(16'h0050 + i));
    cyc(1'b1, 1'b0, STAT, 16'h0000);
    cyc(1'b0, 1'b1, STAT, 16'h0004);
    cyc(1'b1, 1'b0, STAT, 16'h0000);
    g_txr = 1'b1; idle(9); g_txr = 1'b0;

    // RX fill to full, read out, underflow on the ninth read.
    g_rxd = 12'h001; g_rxv = 1'b1; idle(10); g_rxv = 1'b0;
    cyc(1'b1, 1'b0, STAT, 16'h0000);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, BASE, 16'h0000);
    cyc(1'b1, 1'b0, STAT, 16'h0000);
    cyc(1'b0, 1'b1, STAT, 16'h0004);

    // Write to full TX while the sink pops on the same edge.
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, BASE, 16'(16'h0200 + i));
    g_txr = 1'b1; cyc(1'b0, 1'b1, BASE, 16'h0FFF); g_txr = 1'b0;
    cyc(1'b1, 1'b0, STAT, 16'h0000);
    cyc(1'b0, 1'b1, STAT, 16'h0004);
    g_txr = 1'b1; idle(8); g_txr = 1'b0;

    // Flush both FIFOs while a pop and a push happen on the same edge.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, BASE, 16'(16'h0300 + i));
    g_rxv = 1'b1; idle(2);
    g_txr = 1'b1; cyc(1'b0, 1'b1, STAT, 16'h0003);
    g_txr = 1'b0; g_rxv = 1'b0;
    cyc(1'b1, 1'b0, STAT, 16'h0000);

    // Async reset in the middle of a drain at count 5.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, BASE, 16'(16'h0400 + i));
    g_rxv = 1'b1; idle(2);
    g_txr = 1'b1; idle(1);
    do_reset();
    g_txr = 1'b0; g_rxv = 1'b0;
    cyc(1'b1, 1'b0, STAT, 16'h0000);

    // Random traffic.
    g_rand = 1'b1;
    txbias = 2; rxbias = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        txbias = $urandom_range(0, 4);
        rxbias = $urandom_range(0, 4);
      end
      g_txr = ($urandom_range(0, 3) < txbias);
      g_rxv = ($urandom_range(0, 3) < rxbias);
      op = $urandom_range(0, 99);
      wd = 16'($urandom);
      if (op < 35)      cyc(1'b0, 1'b1, BASE, wd);
      else if (op < 60) cyc(1'b1, 1'b0, BASE, 16'h0000);
      else if (op < 68) cyc(1'b1, 1'b0, STAT, 16'h0000);
      else if (op < 73) cyc(1'b0, 1'b1, STAT, wd & (($urandom_range(0, 3) == 0) ? 16'h0007 : 16'h0004));
      else if (op < 78) cyc(1'b1, 1'b1, BASE, wd);
      else if (op < 85) begin
        a = 16'($urandom);
        if (a[15:1] == BASE[15:1]) a = 16'h1234;
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      end
      else cyc(1'b0, 1'b0, BASE, 16'h0000);
    end

    g_txr = 1'b0; g_rxv = 1'b0;
    cyc(1'b1, 1'b0, STAT, 16'h0000);
    idle(2);
    check("tx_scoreboard_empty", 16'(sb_tx.size()), 16'h0000);
    check("rd_scoreboard_empty", 16'(sb_rd.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
